// File: rtl/stat_bcd.sv
// Status formatter: binary pass/fail/freq -> packed BCD, mm:ss BCD timer, underline marks.
// Optional STOP_ON_FAIL_EN freezes the timer and heartbeat while fail_cnt != 0.
module stat_bcd #(
    parameter int CLK_HZ = 14000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        clear,
    input  logic [31:0] pass_cnt,
    input  logic [31:0] fail_cnt,
    input  logic [15:0] freq_bin,
    output logic [31:0] rez1,
    output logic [31:0] rez2,
    output logic [15:0] elapsed,
    output logic [15:0] freq,
    output logic [7:0]  mark
);

    typedef enum logic [1:0] {LOAD, SHIFT, WRITE} state_t;

    localparam logic [31:0] PRESC_TC   = 32'(CLK_HZ - 1);
    localparam logic [31:0] PRESC_HALF = 32'(CLK_HZ / 2);

    state_t      state, state_nxt;
    logic [1:0]  slot;
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [4:0]  iter;
    logic        sat;

    logic [31:0] src;
    logic        src_sat;
    logic [39:0] bcd_adj;
    logic [71:0] dd_nxt;

    always_comb begin
        src     = 32'd0;
        src_sat = 1'b0;
        case (slot)
            2'd0:    src = pass_cnt;
            2'd1:    src = fail_cnt;
            default: src = {16'd0, freq_bin};
        endcase
        if (slot == 2'd2) src_sat = (src > 32'd9999);
        else              src_sat = (src > 32'd99999999);
    end

    // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        dd_nxt = {bcd_adj, bin} << 1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (iter == 5'd31) state_nxt = WRITE;
            WRITE:   state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            slot  <= 2'd0;
            bin   <= 32'd0;
            bcd   <= 40'd0;
            iter  <= 5'd0;
            sat   <= 1'b0;
            rez1  <= 32'd0;
            rez2  <= 32'd0;
            freq  <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    bin  <= src;
                    bcd  <= 40'd0;
                    iter <= 5'd0;
                    sat  <= src_sat;
                end
                SHIFT: begin
                    bcd  <= dd_nxt[71:32];
                    bin  <= dd_nxt[31:0];
                    iter <= iter + 5'd1;
                end
                WRITE: begin
                    case (slot)
                        2'd0:    rez1 <= sat ? 32'h99999999 : bcd[31:0];
                        2'd1:    rez2 <= sat ? 32'h99999999 : bcd[31:0];
                        default: freq <= sat ? 16'h9999 : bcd[15:0];
                    endcase
                    slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
                end
                default: ;
            endcase
        end
    end

    logic [31:0] presc;
    logic        fail_ok;
    logic        wrap;
    logic        tick;
    logic [15:0] elapsed_inc;

`ifdef STOP_ON_FAIL_EN
    assign fail_ok = (fail_cnt == 32'd0);
`else
    assign fail_ok = 1'b1;
`endif

    assign wrap = run && (presc == PRESC_TC);
    assign tick = wrap && fail_ok;

    // BCD mm:ss increment; 99:59 is sticky.
    always_comb begin
        elapsed_inc = elapsed;
        if (elapsed != 16'h9959) begin
            if (elapsed[3:0] != 4'd9) begin
                elapsed_inc[3:0] = elapsed[3:0] + 4'd1;
            end else begin
                elapsed_inc[3:0] = 4'd0;
                if (elapsed[7:4] != 4'd5) begin
                    elapsed_inc[7:4] = elapsed[7:4] + 4'd1;
                end else begin
                    elapsed_inc[7:4] = 4'd0;
                    if (elapsed[11:8] != 4'd9) begin
                        elapsed_inc[11:8] = elapsed[11:8] + 4'd1;
                    end else begin
                        elapsed_inc[11:8]  = 4'd0;
                        elapsed_inc[15:12] = elapsed[15:12] + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= 32'd0;
            elapsed <= 16'd0;
            mark    <= 8'd0;
        end else begin
            if (clear)    presc <= 32'd0;
            else if (run) presc <= wrap ? 32'd0 : presc + 32'd1;

            if (clear)     elapsed <= 16'd0;
            else if (tick) elapsed <= elapsed_inc;

            mark <= {{4{run && (presc < PRESC_HALF) && fail_ok}}, {4{run}}};
        end
    end

endmodule
